// File: rtl/load_store_buffer.sv
// In-order load/store queue: snoops ALU/load CDBs, issues the head to ALU_LS when ready.
// Optional `LSB_ISSUE_BYPASS_EN lets the head issue in the same cycle a CDB supplies its last operand.
module load_store_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        DSP_valid,
  input  logic [5:0]  DSP_OP_ID,
  input  logic [31:0] DSP_inst_pc,
  input  logic        DSP_rs1_ready,
  input  logic        DSP_rs2_ready,
  input  logic [31:0] DSP_rs1_val,
  input  logic [31:0] DSP_rs2_val,
  input  logic [3:0]  DSP_rs1_tag,
  input  logic [3:0]  DSP_rs2_tag,
  input  logic [31:0] DSP_imm,
  input  logic [3:0]  DSP_ROB_id,
  output logic        LSB_full,
  input  logic        ALU_CDB_valid,
  input  logic [3:0]  ALU_CDB_ROB_id,
  input  logic [31:0] ALU_CDB_value,
  input  logic        LS_CDB_valid,
  input  logic [3:0]  LS_CDB_ROB_id,
  input  logic [31:0] LS_CDB_value,
  input  logic [3:0]  ROB_head_id,
  input  logic        ROB_roll_back_flag,
  input  logic        ALU_enable,
  output logic        ALU_input_valid,
  output logic [5:0]  ALU_OP_ID,
  output logic [31:0] ALU_inst_pc,
  output logic [31:0] ALU_reg_rs1,
  output logic [31:0] ALU_reg_rs2,
  output logic [31:0] ALU_imm,
  output logic [3:0]  ALU_ROB_id
);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [5:0] {
    OP_LB = 6'd11, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
  } op_e;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  rob;
    logic        r1_rdy;
    logic [3:0]  r1_tag;
    logic [31:0] r1_val;
    logic        r2_rdy;
    logic [3:0]  r2_tag;
    logic [31:0] r2_val;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          vld_q, vld_d;
  logic [5:0]    op_q, op_d;
  logic [31:0]   pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [3:0]    rob_q, rob_d;

  entry_t        hd, nw;
  logic [32:0]   byp1, byp2;
  logic          r1ok, r2ok, is_load, can_issue, accept;
  logic [31:0]   r1v, r2v;

  // Returns {ready, value} after checking both result buses against the operand tag.
  function automatic logic [32:0] snoop(input logic rdy_in, input logic [3:0] tag,
                                        input logic [31:0] val);
    if (rdy_in)                                  return {1'b1, val};
    else if (ALU_CDB_valid && ALU_CDB_ROB_id == tag) return {1'b1, ALU_CDB_value};
    else if (LS_CDB_valid && LS_CDB_ROB_id == tag)   return {1'b1, LS_CDB_value};
    else                                         return {1'b0, val};
  endfunction

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    full_d  = full_q;
    vld_d   = vld_q;
    op_d    = op_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    rob_d   = rob_q;

    hd   = ent_q[head_q];
    byp1 = snoop(hd.r1_rdy, hd.r1_tag, hd.r1_val);
    byp2 = snoop(hd.r2_rdy, hd.r2_tag, hd.r2_val);
`ifdef LSB_ISSUE_BYPASS_EN
    r1ok = byp1[32];
    r2ok = byp2[32];
`else
    r1ok = hd.r1_rdy;
    r2ok = hd.r2_rdy;
`endif
    // Values always come from the snoop path; without bypass they equal the stored value.
    r1v = byp1[31:0];
    r2v = byp2[31:0];
    is_load = hd.op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    // vld_q marks an issue in the previous cycle; ALU_enable has not caught up yet.
    can_issue = hd.valid && r1ok && r2ok && ALU_enable && !vld_q &&
                (!is_load || hd.rob == ROB_head_id);
    accept = DSP_valid && (count_q != (PW+1)'(DEPTH));

    nw        = '0;
    nw.valid  = 1'b1;
    nw.op     = DSP_OP_ID;
    nw.pc     = DSP_inst_pc;
    nw.imm    = DSP_imm;
    nw.rob    = DSP_ROB_id;
    nw.r1_tag = DSP_rs1_tag;
    nw.r2_tag = DSP_rs2_tag;
    {nw.r1_rdy, nw.r1_val} = snoop(DSP_rs1_ready, DSP_rs1_tag, DSP_rs1_val);
    {nw.r2_rdy, nw.r2_val} = snoop(DSP_rs2_ready, DSP_rs2_tag, DSP_rs2_val);

    if (rdy) begin
      if (ROB_roll_back_flag) begin
        for (int unsigned i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        full_d  = 1'b0;
        vld_d   = 1'b0;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          {ent_d[i].r1_rdy, ent_d[i].r1_val} = snoop(ent_q[i].r1_rdy, ent_q[i].r1_tag, ent_q[i].r1_val);
          {ent_d[i].r2_rdy, ent_d[i].r2_val} = snoop(ent_q[i].r2_rdy, ent_q[i].r2_tag, ent_q[i].r2_val);
        end
        vld_d = can_issue;
        if (can_issue) begin
          op_d  = hd.op;
          pc_d  = hd.pc;
          rs1_d = r1v;
          rs2_d = r2v;
          imm_d = hd.imm;
          rob_d = hd.rob;
          ent_d[head_q].valid = 1'b0;
          head_d = head_q + 1'b1;
        end
        if (accept) begin
          ent_d[tail_q] = nw;
          tail_d = tail_q + 1'b1;
        end
        count_d = count_q + (PW+1)'(accept) - (PW+1)'(can_issue);
        full_d  = count_d >= (PW+1)'(DEPTH - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      vld_q   <= 1'b0;
      op_q    <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      rob_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      vld_q   <= vld_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      rob_q   <= rob_d;
    end
  end

  assign LSB_full        = full_q;
  assign ALU_input_valid = vld_q;
  assign ALU_OP_ID       = op_q;
  assign ALU_inst_pc     = pc_q;
  assign ALU_reg_rs1     = rs1_q;
  assign ALU_reg_rs2     = rs2_q;
  assign ALU_imm         = imm_q;
  assign ALU_ROB_id      = rob_q;
endmodule

// File: tb/tb_load_store_buffer.sv
// Self-checking bench for load_store_buffer: directed scenarios then random traffic vs a queue model.
module tb_load_store_buffer;
  localparam int DEPTH = 16;
  localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15,
                         SB = 6'd16, SH = 6'd17, SW = 6'd18;

  logic        clk = 1'b0;
  logic        rst, rdy, DSP_valid, DSP_rs1_ready, DSP_rs2_ready;
  logic [5:0]  DSP_OP_ID;
  logic [31:0] DSP_inst_pc, DSP_rs1_val, DSP_rs2_val, DSP_imm;
  logic [3:0]  DSP_rs1_tag, DSP_rs2_tag, DSP_ROB_id;
  logic        LSB_full;
  logic        ALU_CDB_valid, LS_CDB_valid;
  logic [3:0]  ALU_CDB_ROB_id, LS_CDB_ROB_id, ROB_head_id;
  logic [31:0] ALU_CDB_value, LS_CDB_value;
  logic        ROB_roll_back_flag, ALU_enable;
  logic        ALU_input_valid;
  logic [5:0]  ALU_OP_ID;
  logic [31:0] ALU_inst_pc, ALU_reg_rs1, ALU_reg_rs2, ALU_imm;
  logic [3:0]  ALU_ROB_id;

  load_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .DSP_valid(DSP_valid), .DSP_OP_ID(DSP_OP_ID), .DSP_inst_pc(DSP_inst_pc),
    .DSP_rs1_ready(DSP_rs1_ready), .DSP_rs2_ready(DSP_rs2_ready),
    .DSP_rs1_val(DSP_rs1_val), .DSP_rs2_val(DSP_rs2_val),
    .DSP_rs1_tag(DSP_rs1_tag), .DSP_rs2_tag(DSP_rs2_tag),
    .DSP_imm(DSP_imm), .DSP_ROB_id(DSP_ROB_id), .LSB_full(LSB_full),
    .ALU_CDB_valid(ALU_CDB_valid), .ALU_CDB_ROB_id(ALU_CDB_ROB_id), .ALU_CDB_value(ALU_CDB_value),
    .LS_CDB_valid(LS_CDB_valid), .LS_CDB_ROB_id(LS_CDB_ROB_id), .LS_CDB_value(LS_CDB_value),
    .ROB_head_id(ROB_head_id), .ROB_roll_back_flag(ROB_roll_back_flag), .ALU_enable(ALU_enable),
    .ALU_input_valid(ALU_input_valid), .ALU_OP_ID(ALU_OP_ID), .ALU_inst_pc(ALU_inst_pc),
    .ALU_reg_rs1(ALU_reg_rs1), .ALU_reg_rs2(ALU_reg_rs2), .ALU_imm(ALU_imm), .ALU_ROB_id(ALU_ROB_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] pc, imm;
    logic [3:0]  rob;
    bit          r1ok, r2ok;
    logic [3:0]  r1tag, r2tag;
    logic [31:0] r1val, r2val;
  } mentry_t;

  mentry_t     mq[$];
  logic        e_valid, e_full;
  logic [5:0]  e_op;
  logic [31:0] e_pc, e_rs1, e_rs2, e_imm;
  logic [3:0]  e_rob;
  int          checks = 0;
  int          failures = 0;

  function automatic bit cdb_hit(input logic [3:0] tag, output logic [31:0] v);
    v = '0;
    if (ALU_CDB_valid && ALU_CDB_ROB_id == tag) begin v = ALU_CDB_value; return 1'b1; end
    if (LS_CDB_valid && LS_CDB_ROB_id == tag) begin v = LS_CDB_value; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit is_load(input logic [5:0] op);
    return op == LB || op == LH || op == LW || op == LBU || op == LHU;
  endfunction

  // Spec-level model of one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit iss, acc, ok1, ok2;
    logic [31:0] v;
    mentry_t h, n;
    if (!rst) begin
      mq.delete();
      e_valid = 0; e_full = 0; e_op = '0; e_pc = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_rob = '0;
      return;
    end
    if (!rdy) return;
    if (ROB_roll_back_flag) begin
      mq.delete();
      e_valid = 0; e_full = 0;
      return;
    end
    iss = 0;
    if (mq.size() > 0) begin
      h = mq[0];
      ok1 = h.r1ok;
      ok2 = h.r2ok;
`ifdef LSB_ISSUE_BYPASS_EN
      if (!ok1) ok1 = cdb_hit(h.r1tag, v);
      if (!ok2) ok2 = cdb_hit(h.r2tag, v);
`endif
      iss = ok1 && ok2 && ALU_enable && !e_valid && (!is_load(h.op) || h.rob == ROB_head_id);
    end
    foreach (mq[i]) begin
      if (!mq[i].r1ok && cdb_hit(mq[i].r1tag, v)) begin mq[i].r1ok = 1; mq[i].r1val = v; end
      if (!mq[i].r2ok && cdb_hit(mq[i].r2tag, v)) begin mq[i].r2ok = 1; mq[i].r2val = v; end
    end
    acc = DSP_valid && mq.size() < DEPTH;
    if (iss) begin
      h = mq.pop_front();
      e_op = h.op; e_pc = h.pc; e_rs1 = h.r1val; e_rs2 = h.r2val; e_imm = h.imm; e_rob = h.rob;
    end
    e_valid = iss;
    if (acc) begin
      n.op = DSP_OP_ID; n.pc = DSP_inst_pc; n.imm = DSP_imm; n.rob = DSP_ROB_id;
      n.r1ok = DSP_rs1_ready; n.r1tag = DSP_rs1_tag; n.r1val = DSP_rs1_val;
      n.r2ok = DSP_rs2_ready; n.r2tag = DSP_rs2_tag; n.r2val = DSP_rs2_val;
      if (!n.r1ok && cdb_hit(n.r1tag, v)) begin n.r1ok = 1; n.r1val = v; end
      if (!n.r2ok && cdb_hit(n.r2tag, v)) begin n.r2ok = 1; n.r2val = v; end
      mq.push_back(n);
    end
    e_full = mq.size() >= DEPTH - 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", 32'(ALU_input_valid), 32'(e_valid));
    chk("full", 32'(LSB_full), 32'(e_full));
    chk("op", 32'(ALU_OP_ID), 32'(e_op));
    chk("pc", ALU_inst_pc, e_pc);
    chk("rs1", ALU_reg_rs1, e_rs1);
    chk("rs2", ALU_reg_rs2, e_rs2);
    chk("imm", ALU_imm, e_imm);
    chk("rob", 32'(ALU_ROB_id), 32'(e_rob));
  endtask

  task automatic dsp(input logic [5:0] op, input logic [31:0] pc,
                     input logic r1ok, input logic [31:0] r1v, input logic [3:0] r1t,
                     input logic r2ok, input logic [31:0] r2v, input logic [3:0] r2t,
                     input logic [31:0] imm, input logic [3:0] rob);
    DSP_valid = 1; DSP_OP_ID = op; DSP_inst_pc = pc;
    DSP_rs1_ready = r1ok; DSP_rs1_val = r1v; DSP_rs1_tag = r1t;
    DSP_rs2_ready = r2ok; DSP_rs2_val = r2v; DSP_rs2_tag = r2t;
    DSP_imm = imm; DSP_ROB_id = rob;
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    rst = 0; rdy = 1; ALU_enable = 1; ROB_roll_back_flag = 0; ROB_head_id = '0;
    ALU_CDB_valid = 0; ALU_CDB_ROB_id = '0; ALU_CDB_value = '0;
    LS_CDB_valid = 0; LS_CDB_ROB_id = '0; LS_CDB_value = '0;
    dsp(SW, '0, 0, '0, '0, 0, '0, '0, '0, '0);
    DSP_valid = 0;

    // Reset for two cycles, then release with ALU_enable high.
    step(); step();
    rst = 1;
    step();
    chk("rst_valid", 32'(ALU_input_valid), 32'd0);
    chk("rst_full", 32'(LSB_full), 32'd0);
    chk("rst_rs1", ALU_reg_rs1, 32'd0);

    // Ready store issues the cycle after dispatch.
    dsp(SW, 32'h1000, 1, 32'h100, 4'd0, 1, 32'hAB, 4'd0, 32'd4, 4'd3);
    step();
    DSP_valid = 0;
    step();
    chk("sw_valid", 32'(ALU_input_valid), 32'd1);
    chk("sw_rob", 32'(ALU_ROB_id), 32'd3);
    chk("sw_rs1", ALU_reg_rs1, 32'h100);
    chk("sw_imm", ALU_imm, 32'd4);
    step();
    chk("sw_bubble", 32'(ALU_input_valid), 32'd0);

    // Load waits for ROB head.
    ROB_head_id = 4'd2;
    dsp(LW, 32'h1004, 1, 32'h300, 4'd0, 1, 32'd0, 4'd0, 32'd8, 4'd5);
    step();
    DSP_valid = 0;
    repeat (3) begin step(); chk("lw_wait", 32'(ALU_input_valid), 32'd0); end
    ROB_head_id = 4'd5;
    step();
    chk("lw_issue", 32'(ALU_input_valid), 32'd1);
    chk("lw_rob", 32'(ALU_ROB_id), 32'd5);
    step();

    // Store waiting on rs2 tag 7, resolved by the ALU CDB.
    dsp(SB, 32'h1008, 1, 32'h200, 4'd0, 0, 32'd0, 4'd7, 32'd1, 4'd6);
    step();
    DSP_valid = 0;
    step();
    chk("sb_wait", 32'(ALU_input_valid), 32'd0);
    ALU_CDB_valid = 1; ALU_CDB_ROB_id = 4'd7; ALU_CDB_value = 32'h5A;
    step();
    ALU_CDB_valid = 0;
`ifdef LSB_ISSUE_BYPASS_EN
    chk("sb_byp_valid", 32'(ALU_input_valid), 32'd1);
    chk("sb_byp_rs2", ALU_reg_rs2, 32'h5A);
    step();
`else
    chk("sb_nobyp_wait", 32'(ALU_input_valid), 32'd0);
    step();
    chk("sb_valid", 32'(ALU_input_valid), 32'd1);
    chk("sb_rs2", ALU_reg_rs2, 32'h5A);
`endif
    step();

    // Fill to the full threshold with ALU_enable low, then drain with wrap.
    ALU_enable = 0;
    for (int i = 0; i < 15; i++) begin
      dsp(SW, 32'h2000 + 32'(4 * i), 1, 32'(i), 4'd0, 1, 32'(i + 100), 4'd0, 32'd0, 4'(i));
      step();
      if (i == 13) chk("full_at14", 32'(LSB_full), 32'd0);
    end
    DSP_valid = 0;
    chk("full_at15", 32'(LSB_full), 32'd1);
    ALU_enable = 1;
    step();
    chk("drain0_rob", 32'(ALU_ROB_id), 32'd0);
    chk("drain0_valid", 32'(ALU_input_valid), 32'd1);
    step();
    chk("drain_bubble", 32'(ALU_input_valid), 32'd0);
    step();
    chk("drain1_rob", 32'(ALU_ROB_id), 32'd1);
    for (int c = 0; c < 40; c++) begin
      if (!e_full && (c % 3 == 0))
        dsp(SH, 32'h3000 + 32'(c), 1, 32'(c), 4'd0, 1, 32'(c * 7), 4'd0, 32'(c), 4'(c));
      else
        DSP_valid = 0;
      step();
    end
    DSP_valid = 0;
    repeat (40) step();

    // Roll-back with six entries queued and a same-cycle dispatch.
    ALU_enable = 0;
    for (int i = 0; i < 6; i++) begin
      dsp(SW, 32'h4000 + 32'(i), 1, 32'(i), 4'd0, 1, 32'(i), 4'd0, 32'd0, 4'(i));
      step();
    end
    ROB_roll_back_flag = 1;
    dsp(SW, 32'h5000, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0, 32'd0, 4'd9);
    step();
    ROB_roll_back_flag = 0;
    DSP_valid = 0;
    chk("rb_full", 32'(LSB_full), 32'd0);
    ALU_enable = 1;
    repeat (5) begin step(); chk("rb_noissue", 32'(ALU_input_valid), 32'd0); end

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom % 8) != 0;
      rst = ($urandom % 500) != 0;
      ROB_roll_back_flag = ($urandom % 100) == 0;
      ALU_enable = ($urandom % 4) != 0;
      if (($urandom % 4) == 0) ROB_head_id = 4'($urandom % 16);
      ALU_CDB_valid = $urandom % 2;
      ALU_CDB_ROB_id = 4'($urandom % 16);
      ALU_CDB_value = $urandom;
      LS_CDB_valid = $urandom % 2;
      LS_CDB_ROB_id = ALU_CDB_ROB_id + 4'(1 + $urandom % 15);
      LS_CDB_value = $urandom;
      if (!e_full && ($urandom % 2) == 1)
        dsp(ops[$urandom % 8], $urandom, 1'($urandom % 2), $urandom, 4'($urandom % 16),
            1'($urandom % 2), $urandom, 4'($urandom % 16), $urandom, 4'($urandom % 16));
      else
        DSP_valid = 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_buffer.md
# load_store_buffer

In-order load/store queue between dispatch and the load/store execution unit (`ALU_LS`). Holds up to `DEPTH` memory instructions, snoops the ALU and load result buses to resolve operand tags, and issues the queue head to `ALU_LS` once its operands are ready. Loads issue only when they are the ROB head, so a load never passes an uncommitted store. Roll-back clears the queue.

## Interface
- `DEPTH`, 16, queue entries; power of two, at most 16 (ROB id is 4 bits).
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `rdy`  in  1  global ready; low = hold all state and outputs.
- `DSP_valid`  in  1  dispatch a memory instruction this cycle.
- `DSP_OP_ID`  in  6  opcode id (LB/LH/LW/LBU/LHU/SB/SH/SW).
- `DSP_inst_pc`  in  32  instruction pc.
- `DSP_rs1_ready`, `DSP_rs2_ready`  in  1 each  operand value valid.
- `DSP_rs1_val`, `DSP_rs2_val`  in  32 each  operand value when ready.
- `DSP_rs1_tag`, `DSP_rs2_tag`  in  4 each  producing ROB id when not ready.
- `DSP_imm`  in  32  offset.
- `DSP_ROB_id`  in  4  ROB entry of this instruction.
- `LSB_full`  out  1  registered; dispatch must not assert `DSP_valid` while high.
- `ALU_CDB_valid`, `ALU_CDB_ROB_id`[4], `ALU_CDB_value`[32]  in  ALU result broadcast.
- `LS_CDB_valid`, `LS_CDB_ROB_id`[4], `LS_CDB_value`[32]  in  load result broadcast.
- `ROB_head_id`  in  4  ROB id of the oldest uncommitted instruction.
- `ROB_roll_back_flag`  in  1  flush.
- `ALU_enable`  in  1  `ALU_LS` can accept (registered by `ALU_LS`, one cycle stale).
- `ALU_input_valid`  out  1  issue strobe, one cycle.
- `ALU_OP_ID`[6], `ALU_inst_pc`[32], `ALU_reg_rs1`[32], `ALU_reg_rs2`[32], `ALU_imm`[32], `ALU_ROB_id`[4]  out  issued instruction.

## Operation
- Circular buffer: `head`, `tail` pointers of log2(`DEPTH`) bits, wrap modulo `DEPTH`; `count` of log2(`DEPTH`)+1 bits. Each entry holds op, pc, imm, ROB id, and per operand {ready, tag, value}.
- Dispatch: on `DSP_valid`, write entry at `tail`, `tail`++. If a CDB in the same cycle matches a not-ready dispatch tag, store the CDB value as ready.
- Snoop: every cycle, each valid not-ready operand whose tag equals a valid CDB id captures that value and becomes ready. Both buses are checked; ids never collide.
- Issue eligibility (head only): entry valid, rs1 ready, rs2 ready, `ALU_enable` high, no issue in the previous cycle. Loads additionally require entry ROB id == `ROB_head_id`. Stores need no ROB-head check.
- Issue: drive outputs from the head entry, `ALU_input_valid`=1, `head`++, `count`--.
- Simultaneous dispatch and issue: `count` unchanged. Dispatch into a full queue is a protocol violation; the entry is dropped and `count` unchanged.
- `LSB_full` = (`count` after this cycle's update) >= `DEPTH`-1, so one dispatch in flight always fits.
- Roll-back (while `rdy`): clear all valid bits, `head`=`tail`=`count`=0, `ALU_input_valid`=0, `LSB_full`=0. The same-cycle dispatch and CDB are ignored.
- Reset (`rst`=0): same as roll-back, plus all issue data outputs = 0. Reset mid-operation discards all entries.

## Timing
- Dispatch at edge t: the entry is visible at t+1 and can issue at t+1 at the earliest.
- Issue is registered. `ALU_input_valid` is high for exactly the one cycle after the decision edge.
- Mandatory bubble: no issue in the cycle directly after an issue, because `ALU_enable` lags `ALU_LS` state by one cycle. Maximum throughput is one issue per 2 cycles.
- `ALU_input_valid` never stays high for two consecutive cycles.
- A CDB value captured at edge t makes the operand ready at t+1. Issue happens at t+1 at the earliest (see Configuration).
- `rdy`=0: no state change, outputs hold their last values, including `ALU_input_valid`.

## Configuration
- `LSB_ISSUE_BYPASS_EN` defined: the head may issue in the same cycle a CDB supplies its last missing operand. The CDB value goes directly to `ALU_reg_rs1`/`ALU_reg_rs2` and is also written into the entry.
- `LSB_ISSUE_BYPASS_EN` not defined: the operand must already be ready in the entry, which costs one extra cycle.

## Test plan
- Reset with `rst`=0 for 2 cycles, then release -> all outputs 0, `LSB_full`=0, no issue with `ALU_enable`=1.
- Dispatch SW with rs1=0x100, rs2=0xAB, imm=4, ROB id 3, all ready -> next cycle `ALU_input_valid`=1, `ALU_ROB_id`=3, `ALU_reg_rs1`=0x100, `ALU_imm`=4.
- Dispatch LW ROB id 5 with `ROB_head_id`=2 -> no issue. When `ROB_head_id` becomes 5 -> issue on the next edge.
- Dispatch SB with rs2 tag 7 not ready, then `ALU_CDB` id 7 value 0x5A -> `ALU_reg_rs2`=0x5A. With `LSB_ISSUE_BYPASS_EN`, issue in the CDB cycle; without it, issue one cycle later.
- Dispatch 15 ready stores with `ALU_enable`=0 (`DEPTH`=16) -> `LSB_full`=1. Raise `ALU_enable` -> stores issue in order, one every 2 cycles, and pointers wrap correctly after more dispatches.
- Queue holding 6 entries, pulse `ROB_roll_back_flag` together with `DSP_valid` -> queue empty, no issue afterward, dispatched entry discarded.
